// File: rtl/accumulator.sv
// Accumulator: a WIDTH-bit load register with synchronous active-high reset.
// Define ACC_FLAGS_EN to add the ac_z (zero) and ac_n (sign bit) flag outputs.
module accumulator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_ac,
    input  logic [WIDTH-1:0] data_in,
`ifdef ACC_FLAGS_EN
    output logic [WIDTH-1:0] ac_out,
    output logic             ac_z,
    output logic             ac_n
`else
    output logic [WIDTH-1:0] ac_out
`endif
);

    logic [WIDTH-1:0] ac_q;

    // Reset takes priority over load; with neither asserted the register holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            ac_q <= '0;
        end else if (load_ac) begin
            ac_q <= data_in;
        end
    end

    assign ac_out = ac_q;

`ifdef ACC_FLAGS_EN
    // Flags decode only the stored value, so they line up with ac_out.
    assign ac_z = (ac_q == '0);
    assign ac_n = ac_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_accumulator.sv
// Directed self-checking bench for accumulator (default WIDTH = 8).
// The flag checks are included when ACC_FLAGS_EN is defined.
module tb_accumulator;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             load_ac;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] ac_out;
`ifdef ACC_FLAGS_EN
    logic             ac_z;
    logic             ac_n;
`endif

    int checks;
    int errors;

    accumulator #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .load_ac (load_ac),
        .data_in (data_in),
`ifdef ACC_FLAGS_EN
        .ac_out  (ac_out),
        .ac_z    (ac_z),
        .ac_n    (ac_n)
`else
        .ac_out  (ac_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected flag values are written out by hand in each vector.
    task automatic checkAll(input string tag, input logic [WIDTH-1:0] exp_ac,
                            input logic exp_z, input logic exp_n);
        checkOutput({tag, ".ac_out"}, 64'(ac_out), 64'(exp_ac));
`ifdef ACC_FLAGS_EN
        checkOutput({tag, ".ac_z"}, 64'(ac_z), 64'(exp_z));
        checkOutput({tag, ".ac_n"}, 64'(ac_n), 64'(exp_n));
`else
        if (exp_z === 1'bx || exp_n === 1'bx) begin
            $display("[TB] note: %s has unknown expected flags", tag);
        end
`endif
    endtask

    // Drive inputs on the falling edge, then sample just after the next rising edge.
    task automatic applyStimulus(input logic r, input logic l, input logic [WIDTH-1:0] d);
        @(negedge clk);
        reset   = r;
        load_ac = l;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        load_ac = 1'b0;
        data_in = '0;

        // Reset with data present but no load
        applyStimulus(1'b1, 1'b0, 8'd255);
        checkAll("reset", 8'd0, 1'b1, 1'b0);

        // Load 170 (MSB set)
        applyStimulus(1'b0, 1'b1, 8'd170);
        checkAll("load170", 8'd170, 1'b0, 1'b1);

        // Hold while data_in wanders
        applyStimulus(1'b0, 1'b0, 8'd240);
        checkAll("hold240", 8'd170, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'd18);
        checkAll("hold18", 8'd170, 1'b0, 1'b1);

        // Load 31 (positive, nonzero)
        applyStimulus(1'b0, 1'b1, 8'd31);
        checkAll("load31", 8'd31, 1'b0, 1'b0);

        // Reset beats a simultaneous load
        applyStimulus(1'b1, 1'b1, 8'd85);
        checkAll("rst_over_load", 8'd0, 1'b1, 1'b0);

        // Back-to-back loads, each taking effect, including boundary values
        applyStimulus(1'b0, 1'b1, 8'hFF);
        checkAll("b2b_ff", 8'hFF, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h80);
        checkAll("b2b_80", 8'h80, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h7F);
        checkAll("b2b_7f", 8'h7F, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkAll("load_zero", 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h5A);
        checkAll("load5a", 8'h5A, 1'b0, 1'b0);

        // Mid-cycle reset pulse must not reach ac_out
        @(negedge clk);
        load_ac = 1'b0;
        reset   = 1'b1;
        #2;
        checkAll("midrst_during", 8'h5A, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkAll("midrst_after", 8'h5A, 1'b0, 1'b0);

        // Mid-cycle data_in change with load low
        @(negedge clk);
        data_in = 8'hC3;
        #2;
        checkAll("middata_during", 8'h5A, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkAll("middata_after", 8'h5A, 1'b0, 1'b0);

        // Single-bit patterns stored bit-exact
        applyStimulus(1'b0, 1'b1, 8'h01);
        checkAll("load01", 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h01);
        checkAll("reset2", 8'h00, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accumulator.md
ACCUMULATOR -- requirements
Module: accumulator

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the data width of data_in and ac_out in bits (legal range 2..64).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The module SHALL have port load_ac, input, 1 bit, load enable: capture data_in on the next rising clk edge.
REQ-005 The module SHALL have port data_in, input, WIDTH bits, value to be loaded.
REQ-006 The module SHALL have port ac_out, output, WIDTH bits, current accumulator register contents.
REQ-007 When ACC_FLAGS_EN is defined, the module SHALL additionally have port ac_z, output, 1 bit, set when ac_out is all zeros.
REQ-008 When ACC_FLAGS_EN is defined, the module SHALL additionally have port ac_n, output, 1 bit, equal to ac_out[WIDTH-1].

Function
REQ-009 The accumulator SHALL be a single WIDTH-bit register whose value drives ac_out directly (no combinational path from data_in, load_ac or reset to ac_out).
REQ-010 On a rising clk edge with reset=1, the register SHALL become 0, regardless of load_ac and data_in.
REQ-011 On a rising clk edge with reset=0 and load_ac=1, the register SHALL take the value of data_in sampled at that edge; the new value is visible on ac_out after that edge (latency 1 cycle).
REQ-012 On a rising clk edge with reset=0 and load_ac=0, the register SHALL hold its value; data_in changes SHALL have no effect.
REQ-013 Priority SHALL be reset > load > hold; simultaneous reset=1 and load_ac=1 yields 0.
REQ-014 Loads SHALL be unconditional every enabled cycle; back-to-back loads on consecutive edges each take effect.
REQ-015 The register SHALL store data_in bit-exact with no arithmetic, sign extension, truncation or saturation.
REQ-016 ac_z and ac_n (when present) SHALL be combinational decodes of the register only, valid in the same cycle as ac_out.

Reset
REQ-017 Reset SHALL be synchronous and active-high; asserting reset between clock edges SHALL not change ac_out until the next rising edge.
REQ-018 After reset, ac_out SHALL be 0; when ACC_FLAGS_EN is defined, ac_z SHALL be 1 and ac_n SHALL be 0.
REQ-019 Before the first reset edge, the register content is undefined; no initial value is required.

Configuration
REQ-020 Macro ACC_FLAGS_EN SHALL control flag generation: defined -> ports ac_z and ac_n exist and behave per REQ-007/008/016; undefined -> those ports and their logic are absent and all other behaviour is identical.

Verification
REQ-021 reset=1, load_ac=0, data_in=255, one edge -> ac_out=0 (ac_z=1, ac_n=0 with flags).
REQ-022 reset=0, load_ac=1, data_in=170, one edge -> ac_out=170 (ac_n=1, ac_z=0 with flags).
REQ-023 From 170: load_ac=0, data_in=240 then 18, two edges -> ac_out stays 170 after each.
REQ-024 reset=0, load_ac=1, data_in=31, one edge -> ac_out=31 (ac_n=0, ac_z=0).
REQ-025 From 31: reset=1, load_ac=1, data_in=85, one edge -> ac_out=0 (reset wins).
REQ-026 Mid-cycle reset pulse that deasserts before the rising edge, load_ac=0 -> ac_out unchanged; mid-cycle data_in change with load_ac=0 -> ac_out unchanged.
